// File: rtl/sa_weight_loader.sv
// sa_weight_loader: buffers a 1..NUM_ROWS weight tile from a valid/ready stream and
// shifts it into the systolic array bottom-row-first, zero-padding unused rows.
module sa_weight_loader #(
  parameter int DATAWIDTH = 8,
  parameter int NUM_ROWS  = 4,
  parameter int NUM_COLS  = 4,
  parameter int CNT_W     = $clog2(NUM_ROWS + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_start,
  input  logic [CNT_W-1:0]                     i_num_rows,
  input  logic                                 i_wvalid,
  output logic                                 o_wready,
  input  logic [NUM_COLS-1:0][DATAWIDTH-1:0]   i_wdata,
  output logic [NUM_COLS-1:0][DATAWIDTH-1:0]   o_weight,
  output logic                                 o_mode,
  output logic                                 o_load_psum,
  output logic                                 o_busy,
  output logic                                 o_done
);
  localparam int IDX_W = $clog2(NUM_ROWS);
  typedef logic [NUM_COLS-1:0][DATAWIDTH-1:0] row_t;
  typedef enum logic [1:0] {IDLE, COLLECT, SHIFT, DONE} state_t;
  state_t           r_state;
  row_t             r_buf [NUM_ROWS];
  logic [IDX_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] w_n;
  logic [IDX_W-1:0] w_nxt;
  logic             w_last_beat;
  assign w_n         = (i_num_rows > CNT_W'(NUM_ROWS)) ? CNT_W'(NUM_ROWS) : i_num_rows;
  assign w_nxt       = IDX_W'(NUM_ROWS - 2) - r_cnt;
  assign w_last_beat = CNT_W'(r_cnt) == r_n - CNT_W'(1);
  assign o_load_psum = 1'b0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_n      <= '0;
      for (int i = 0; i < NUM_ROWS; i++) r_buf[i] <= '0;
      o_wready <= 1'b0;
      o_mode   <= 1'b1;
      o_weight <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_n    <= w_n;
          r_cnt  <= '0;
          o_busy <= 1'b1;
          for (int i = 0; i < NUM_ROWS; i++) r_buf[i] <= '0;
          if (w_n != '0) begin
            r_state  <= COLLECT;
            o_wready <= 1'b1;
          end else begin
            r_state  <= SHIFT;
            o_mode   <= 1'b0;
            o_weight <= '0;
          end
        end
        COLLECT: if (i_wvalid) begin
          r_buf[r_cnt] <= i_wdata;
          if (w_last_beat) begin
            r_state  <= SHIFT;
            r_cnt    <= '0;
            o_wready <= 1'b0;
            o_mode   <= 1'b0;
            // the top row may be the beat being written on this very edge
            o_weight <= (r_cnt == IDX_W'(NUM_ROWS - 1)) ? i_wdata : r_buf[NUM_ROWS-1];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SHIFT: if (r_cnt == IDX_W'(NUM_ROWS - 1)) begin
          r_state  <= DONE;
          r_cnt    <= '0;
          o_mode   <= 1'b1;
          o_weight <= '0;
          o_done   <= 1'b1;
        end else begin
          r_cnt    <= r_cnt + 1'b1;
          o_weight <= r_buf[w_nxt];
        end
        DONE: begin
          r_state <= IDLE;
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sa_weight_loader.sv
// tb_sa_weight_loader: table-driven and randomized checks of the weight loader against
// a tile-level model (expected shift sequence, latency, handshake count).
module tb_sa_weight_loader;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int NC = 4;
  localparam int CW = $clog2(NR + 1);
  typedef logic [NC-1:0][DW-1:0] row_t;
  typedef struct {
    int   nr;
    row_t rows [NR];
    int   st_after;
    int   st_len;
    bit   inj;
    int   lat;
  } vec_t;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [CW-1:0] i_num_rows = '0;
  logic          i_wvalid = 1'b0;
  logic          o_wready;
  row_t          i_wdata = '0;
  row_t          o_weight;
  logic          o_mode;
  logic          o_load_psum;
  logic          o_busy;
  logic          o_done;
  int            n_checks = 0;
  int            n_fail = 0;
  vec_t          tbl [6];
  sa_weight_loader #(.DATAWIDTH(DW), .NUM_ROWS(NR), .NUM_COLS(NC)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_num_rows(i_num_rows),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata),
    .o_weight(o_weight), .o_mode(o_mode), .o_load_psum(o_load_psum),
    .o_busy(o_busy), .o_done(o_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic row_t mkrow(input int a, input int b, input int c, input int d);
    row_t r;
    r[0] = DW'(a);
    r[1] = DW'(b);
    r[2] = DW'(c);
    r[3] = DW'(d);
    return r;
  endfunction
  task automatic chk_idle(input string nm);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_mode"}, o_mode, 1);
    chk({nm, "_wready"}, o_wready, 0);
    chk({nm, "_done"}, o_done, 0);
    chk({nm, "_weight"}, o_weight, 0);
    chk({nm, "_psum"}, o_load_psum, 0);
  endtask
  // Called at a negedge; returns at the negedge of the first IDLE cycle after done.
  task automatic run_load(input int nr, input row_t rows [NR], input int st_after,
                          input int st_len, input bit inj, input bit rnd, input int exp_lat);
    int   n, beat, e, done_edge, done_cnt, last_hs, first_m0, stalled, m0_cnt;
    bit   v;
    row_t q [$];
    row_t exp_row;
    n = (nr > NR) ? NR : nr;
    beat = 0; done_cnt = 0; done_edge = -1; last_hs = 0; first_m0 = -1;
    stalled = 0; m0_cnt = 0;
    i_start = 1'b1;
    i_num_rows = CW'(nr);
    i_wvalid = 1'b0;
    @(posedge clk);
    e = 0;
    while (done_cnt == 0 && e < 300) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_done) begin
        done_cnt++;
        done_edge = e;
      end
      if (!o_mode) begin
        q.push_back(o_weight);
        if (first_m0 < 0) first_m0 = e;
        m0_cnt++;
        if (inj && m0_cnt == 2) begin
          i_start = 1'b1;
          i_num_rows = CW'(1);
        end
      end
      chk("busy_in_load", o_busy, 1);
      chk("wready", o_wready, (beat < n) ? 1 : 0);
      if (beat < n && beat == st_after && stalled < st_len) begin
        v = 1'b0;
        stalled++;
      end else begin
        v = rnd ? 1'($urandom_range(0, 1)) : (beat < n);
      end
      i_wvalid = v;
      i_wdata = (beat < n) ? rows[beat] : row_t'($urandom);
      if (v && o_wready) begin
        beat++;
        if (beat == n) last_hs = e + 1;
      end
      @(posedge clk);
      e++;
    end
    i_wvalid = 1'b0;
    chk("done_seen", done_cnt, 1);
    chk("beats_taken", beat, n);
    chk("shift_len", q.size(), NR);
    for (int k = 0; k < NR; k++) begin
      exp_row = (NR - 1 - k < n) ? rows[NR-1-k] : row_t'(0);
      if (k < q.size()) chk("shift_row", q[k], exp_row);
    end
    chk("shift_start", first_m0, (n > 0) ? last_hs : 0);
    chk("shift_to_done", done_edge, first_m0 + NR);
    if (exp_lat > 0) chk("latency", done_edge + 1, exp_lat);
    @(negedge clk);
    chk_idle("idle_after");
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    row_t z [NR];
    row_t r [NR];
    for (int i = 0; i < NR; i++) z[i] = '0;
    tbl[0] = '{4, '{mkrow(1,2,3,4), mkrow(5,6,7,8), mkrow(9,10,11,12), mkrow(13,14,15,16)}, -1, 0, 0, 9};
    tbl[1] = '{2, '{mkrow(7,7,7,7), mkrow(9,9,9,9), mkrow(0,0,0,0), mkrow(0,0,0,0)}, -1, 0, 0, 7};
    tbl[2] = '{3, '{mkrow(17,18,19,20), mkrow(33,34,35,36), mkrow(49,50,51,52), mkrow(0,0,0,0)}, 2, 5, 0, 13};
    tbl[3] = '{7, '{mkrow(1,2,3,4), mkrow(5,6,7,8), mkrow(9,10,11,12), mkrow(13,14,15,16)}, -1, 0, 0, 9};
    tbl[4] = '{0, z, -1, 0, 0, 5};
    tbl[5] = '{4, '{mkrow(160,161,162,163), mkrow(176,177,178,179), mkrow(192,193,194,195), mkrow(208,209,210,211)}, -1, 0, 1, 9};
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++)
      run_load(tbl[i].nr, tbl[i].rows, tbl[i].st_after, tbl[i].st_len, tbl[i].inj, 1'b0, tbl[i].lat);
    repeat (3) begin
      @(negedge clk);
      chk_idle("stay_idle");
    end
    // asynchronous reset during the second shift cycle
    i_start = 1'b1;
    i_num_rows = CW'(4);
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    for (int b = 0; b < NR; b++) begin
      i_wvalid = 1'b1;
      i_wdata = tbl[0].rows[b];
      @(negedge clk);
    end
    i_wvalid = 1'b0;
    @(negedge clk);
    chk("rst_pre_mode", o_mode, 0);
    chk("rst_pre_weight", o_weight, tbl[0].rows[2]);
    #2 rst = 1'b1;
    #1 chk_idle("async_rst");
    @(posedge clk);
    @(negedge clk);
    chk_idle("rst_held");
    rst = 1'b0;
    @(negedge clk);
    run_load(tbl[0].nr, tbl[0].rows, -1, 0, 1'b0, 1'b0, tbl[0].lat);
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < NR; i++) r[i] = row_t'($urandom);
      run_load($urandom_range(0, 7), r, -1, 0, 1'b0, 1'b1, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
